// File: rtl/tone_generator_pkg.sv
// Shared note table, FSM encoding and helpers for the tone generator.
// The optional input glitch filter is enabled by TONE_GLITCH_FILTER_EN.
package tone_generator_pkg;

  localparam int CODE_W    = 5;
  localparam int NUM_NOTES = 21;

  // C4 .. G#5, one semitone per code
  localparam int FREQ_HZ [1:NUM_NOTES] = '{
    262, 277, 294, 311, 330, 349, 370,
    392, 415, 440, 466, 494, 523, 554,
    587, 622, 659, 698, 740, 784, 831
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  function automatic int half_period(
    input int clk_hz,
    input int code
  );
    if (code < 1 || code > NUM_NOTES)
      return 0;
    return clk_hz / (2 * FREQ_HZ[code]);
  endfunction

  function automatic logic code_valid(
    input logic [CODE_W-1:0] c
  );
    return (c != '0) &&
           (c <= CODE_W'(NUM_NOTES));
  endfunction

endpackage

// File: rtl/tone_generator_lut.sv
// Code to half-period lookup; the table is built at elaboration.
// Invalid codes map to a half-period of zero.
module tone_lut
  import tone_generator_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 17
) (
  input  logic [CODE_W-1:0] code,
  output logic [CNT_W-1:0]  half
);

  logic [CNT_W-1:0] tbl [2**CODE_W];

  for (genvar i = 0; i < 2**CODE_W; i++) begin : g_tbl
    assign tbl[i] = CNT_W'(half_period(CLK_HZ, i));
  end

  assign half = tbl[code];

endmodule

// File: rtl/tone_generator.sv
// Square-wave speaker driver fed by the key encoder's note code.
// Define TONE_GLITCH_FILTER_EN to require a code to settle before use.
module tone_generator
  import tone_generator_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int CNT_W         = 17
`ifdef TONE_GLITCH_FILTER_EN
  ,
  parameter int STABLE_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] key_code,
  output logic              tone_out,
  output logic              playing,
  output logic [CODE_W-1:0] cur_code
);

  state_t            state;
  state_t            state_nxt;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] acc_code;
  logic [CNT_W-1:0]  half_q;
  logic [CNT_W-1:0]  half_new;
  logic [CNT_W-1:0]  cnt;
  logic              acc_valid;
  logic              tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) code_q <= '0;
    else     code_q <= key_code;
  end

`ifdef TONE_GLITCH_FILTER_EN
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

  logic [CODE_W-1:0] last_q;
  logic [STAB_W-1:0] stab_q;

  // acc_code only follows code_q once it has stopped moving
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= '0;
      stab_q   <= '0;
      acc_code <= '0;
    end else if (code_q != last_q) begin
      last_q <= code_q;
      stab_q <= '0;
    end else if (stab_q ==
                 STAB_W'(STABLE_CYCLES - 1)) begin
      acc_code <= last_q;
    end else begin
      stab_q <= stab_q + STAB_W'(1);
    end
  end
`else
  assign acc_code = code_q;
`endif

  assign acc_valid = code_valid(acc_code);
  assign tc = (cnt == half_q - CNT_W'(1));

  tone_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .code (acc_code),
    .half (half_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (acc_valid) state_nxt = LOAD;
      LOAD: state_nxt = acc_valid ? PLAY : IDLE;
      PLAY: begin
        if (!acc_valid)
          state_nxt = IDLE;
        else if (acc_code != cur_code)
          state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    playing = (state == PLAY);
  end

  // leaving PLAY wins over a terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q   <= '0;
      cnt      <= '0;
      tone_out <= 1'b0;
      cur_code <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          half_q   <= half_new;
          cur_code <= acc_valid ? acc_code : '0;
          cnt      <= '0;
          tone_out <= 1'b0;
        end
        PLAY: begin
          if (state_nxt != PLAY) begin
            cnt      <= '0;
            tone_out <= 1'b0;
            if (state_nxt == IDLE)
              cur_code <= '0;
          end else if (tc) begin
            cnt      <= '0;
            tone_out <= ~tone_out;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt      <= '0;
          tone_out <= 1'b0;
          cur_code <= '0;
        end
      endcase
    end
  end

endmodule
